// File: rtl/multicycle_controller_pkg.sv
// ============================================================================
// Module  : multicycle_controller_pkg
// Brief   : Shared encodings for the multicycle MIPS controller: state codes,
//           opcode/funct constants, datapath select encodings and the
//           instruction classifier used by both decode and next-state logic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_controller_pkg;

  // FSM state encoding, exposed on the debug state port
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_I     = 4'd8,
    S_WB_LW    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd15
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type funct codes
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;

  // Datapath select encodings
  localparam logic [1:0] ALUC_ADD     = 2'b00;
  localparam logic [1:0] ALUC_SUB     = 2'b01;
  localparam logic [1:0] ALUC_AND     = 2'b10;
  localparam logic [1:0] ALUC_OR      = 2'b11;
  localparam logic [1:0] PCSRC_PC4    = 2'b00;
  localparam logic [1:0] PCSRC_ALU    = 2'b01;
  localparam logic [1:0] PCSRC_BRANCH = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;
  localparam logic [1:0] REG2REG_MEM  = 2'b00;
  localparam logic [1:0] REG2REG_ALU  = 2'b01;
  localparam logic [1:0] REG2REG_PC4  = 2'b10;
  localparam logic [1:0] REGRT_RD     = 2'b00;
  localparam logic [1:0] REGRT_RT     = 2'b01;
  localparam logic [1:0] REGRT_R31    = 2'b10;

  // Coarse instruction class driving the DECODE dispatch
  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_IMM     = 3'd1,
    CLS_LW      = 3'd2,
    CLS_SW      = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JUMP    = 3'd5,
    CLS_SYSCALL = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_t;

  function automatic instr_class_t classify(input logic [5:0] op, input logic [5:0] fn);
    instr_class_t cls;
    cls = CLS_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR: cls = CLS_R;
          FN_SYSCALL:                    cls = CLS_SYSCALL;
          default:                       cls = CLS_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI: cls = CLS_IMM;
      OP_LW:                    cls = CLS_LW;
      OP_SW:                    cls = CLS_SW;
      OP_BEQ, OP_BNE:           cls = CLS_BRANCH;
      OP_J, OP_JAL:             cls = CLS_JUMP;
      default:                  cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  // ALU operation for arithmetic instructions (R-type by funct, I-type by opcode)
  function automatic logic [1:0] alu_ctl(input logic [5:0] op, input logic [5:0] fn);
    logic [1:0] c;
    c = ALUC_ADD;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_SUB:  c = ALUC_SUB;
        FN_AND:  c = ALUC_AND;
        FN_OR:   c = ALUC_OR;
        default: c = ALUC_ADD;
      endcase
    end else if (op == OP_ANDI) begin
      c = ALUC_AND;
    end else if (op == OP_ORI) begin
      c = ALUC_OR;
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_output_decode.sv
// ============================================================================
// Module  : mc_output_decode
// Brief   : Moore control-word decode for the multicycle controller. Maps the
//           current state plus latched opcode/funct, ALU zero and memory
//           ready onto datapath enables and mux selects.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_output_decode
  import multicycle_controller_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  regrt,
  output logic [1:0]  reg2reg,
  output logic        se,
  output logic        aluqb,
  output logic [1:0]  aluc,
  output logic [1:0]  pcsrc
);

  // Per-state control word; everything defaults to inactive / select 0
  always_comb begin
    mem_req   = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    regrt     = REGRT_RD;
    reg2reg   = REG2REG_MEM;
    se        = 1'b0;
    aluqb     = 1'b0;
    aluc      = ALUC_ADD;
    pcsrc     = PCSRC_PC4;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        pcsrc    = PCSRC_PC4;
      end
      S_EXEC_R: begin
        aluqb = 1'b1;
        aluc  = alu_ctl(opcode, funct);
      end
      S_WB_R: begin
        reg_write = 1'b1;
        regrt     = REGRT_RD;
        reg2reg   = REG2REG_ALU;
        aluqb     = 1'b1;
        aluc      = alu_ctl(opcode, funct);
      end
      S_EXEC_I: begin
        aluc = alu_ctl(opcode, funct);
        se   = (opcode == OP_ADDI);
      end
      S_WB_I: begin
        reg_write = 1'b1;
        regrt     = REGRT_RT;
        reg2reg   = REG2REG_ALU;
      end
      S_MEM_ADDR: begin
        se   = 1'b1;
        aluc = ALUC_ADD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
      end
      S_WB_LW: begin
        reg_write = 1'b1;
        regrt     = REGRT_RT;
        reg2reg   = REG2REG_MEM;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = mem_ready;
      end
      S_BRANCH: begin
        aluqb    = 1'b1;
        aluc     = ALUC_SUB;
        se       = 1'b1;
        pcsrc    = PCSRC_BRANCH;
        pc_write = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pcsrc    = PCSRC_JUMP;
        if (opcode == OP_JAL) begin
          reg_write = 1'b1;
          regrt     = REGRT_R31;
          reg2reg   = REG2REG_PC4;
        end
      end
      default: begin
        // DECODE and HALT drive nothing
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module  : multicycle_controller
// Brief   : Moore FSM sequencing a shared-resource multicycle MIPS datapath.
//           Holds state, the opcode/funct latch, sticky halt/illegal flags and
//           cycle/instruction performance counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       regrt,
  output logic [1:0]       reg2reg,
  output logic             se,
  output logic             aluqb,
  output logic [1:0]       aluc,
  output logic [1:0]       pcsrc,
  output logic [3:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  state_t       cur_state;
  state_t       next_state;
  logic [5:0]   op_q;
  logic [5:0]   fn_q;
  instr_class_t cls;

  logic raw_mem_req;
  logic raw_mem_write;
  logic raw_ir_write;
  logic raw_pc_write;
  logic raw_reg_write;

  assign cls   = classify(op_q, fn_q);
  assign state = cur_state;

  mc_output_decode u_decode (
    .state     (cur_state),
    .opcode    (op_q),
    .funct     (fn_q),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (raw_mem_req),
    .mem_write (raw_mem_write),
    .ir_write  (raw_ir_write),
    .pc_write  (raw_pc_write),
    .reg_write (raw_reg_write),
    .regrt     (regrt),
    .reg2reg   (reg2reg),
    .se        (se),
    .aluqb     (aluqb),
    .aluc      (aluc),
    .pcsrc     (pcsrc)
  );

  // Reset is asynchronous, so the FETCH state seen during reset must not leak
  // a memory request or any write strobe onto the datapath.
  assign mem_req   = raw_mem_req   & reset;
  assign mem_write = raw_mem_write & reset;
  assign ir_write  = raw_ir_write  & reset;
  assign pc_write  = raw_pc_write  & reset;
  assign reg_write = raw_reg_write & reset;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cur_state <= S_FETCH;
    else        cur_state <= next_state;
  end

  // Next-state sequencing; memory states stall until mem_ready
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (cls)
          CLS_R:          next_state = S_EXEC_R;
          CLS_IMM:        next_state = S_EXEC_I;
          CLS_LW, CLS_SW: next_state = S_MEM_ADDR;
          CLS_BRANCH:     next_state = S_BRANCH;
          CLS_JUMP:       next_state = S_JUMP;
          default:        next_state = S_HALT;
        endcase
      end
      S_EXEC_R:   next_state = S_WB_R;
      S_EXEC_I:   next_state = S_WB_I;
      S_MEM_ADDR: next_state = (cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) next_state = S_WB_LW;
      S_MEM_WR:   if (mem_ready) next_state = S_FETCH;
      S_WB_R, S_WB_I, S_WB_LW, S_BRANCH, S_JUMP: next_state = S_FETCH;
      S_HALT:     next_state = S_HALT;
      default:    next_state = S_FETCH;
    endcase
  end

  // Opcode/funct latch captured with the instruction register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q <= 6'd0;
      fn_q <= 6'd0;
    end else if (raw_ir_write) begin
      op_q <= opcode;
      fn_q <= funct;
    end
  end

  // Sticky halt and illegal-instruction flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (next_state == S_HALT) halted <= 1'b1;
      if ((cur_state == S_DECODE) && (cls == CLS_ILLEGAL)) illegal <= 1'b1;
    end
  end

  // Performance counters: cycles while running, retirements on return to FETCH
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (cur_state != S_HALT) cycle_count <= cycle_count + 1'b1;
      if ((cur_state != S_FETCH) && (next_state == S_FETCH)) instr_count <= instr_count + 1'b1;
    end
  end

endmodule

`default_nettype wire
